// File: rtl/gtfraw_vnc_reset_sequencer.sv
// GTF raw-mode bring-up sequencer: GT/PLL reset, lock qualification, datapath reset,
// reset-done collection, with timeout, bounded retry and registered status outputs.
module gtfraw_vnc_reset_sequencer #(
    parameter int SYNC_STAGES        = 3,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int LOCK_SETTLE_CYCLES = 256,
    parameter int TIMEOUT_CYCLES     = 65536,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clk,
    input  logic       reset_async,
    input  logic       pll_lock_async,
    input  logic       tx_resetdone_async,
    input  logic       rx_resetdone_async,
    input  logic       retry_req,
    output logic       gt_reset_out,
    output logic       tx_dp_reset_out,
    output logic       rx_dp_reset_out,
    output logic       seq_done,
    output logic       seq_fail,
    output logic [3:0] retry_count,
    output logic [2:0] state_out
);

    localparam int MAX_A = (TIMEOUT_CYCLES > LOCK_SETTLE_CYCLES) ? TIMEOUT_CYCLES : LOCK_SETTLE_CYCLES;
    localparam int MAX_B = (MAX_A > RESET_PULSE_CYCLES) ? MAX_A : RESET_PULSE_CYCLES;
    localparam int CNT_W = $clog2(MAX_B) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(LOCK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GT_RST    = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        DP_RST    = 3'd4,
        WAIT_DONE = 3'd5,
        DONE      = 3'd6,
        FAIL      = 3'd7
    } state_t;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_lock_sync;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_txd_sync;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_rxd_sync;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry;
    logic             r_gt_rst;
    logic             r_dp_rst;
    logic             r_done;
    logic             r_fail;

    state_t w_state_nxt;
    logic   [3:0] w_retry_nxt;
    logic   w_timeout;
    logic   w_lock;
    logic   w_txd;
    logic   w_rxd;

    assign w_lock = r_lock_sync[SYNC_STAGES-1];
    assign w_txd  = r_txd_sync[SYNC_STAGES-1];
    assign w_rxd  = r_rxd_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            r_lock_sync <= '0;
            r_txd_sync  <= '0;
            r_rxd_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock_async};
            r_txd_sync  <= {r_txd_sync[SYNC_STAGES-2:0], tx_resetdone_async};
            r_rxd_sync  <= {r_rxd_sync[SYNC_STAGES-2:0], rx_resetdone_async};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE:      w_state_nxt = GT_RST;
            GT_RST:    if (r_cnt == PULSE_LAST) w_state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle takes precedence.
                if (w_lock)                      w_state_nxt = SETTLE;
                else if (r_cnt == TIMEOUT_LAST)  w_timeout   = 1'b1;
            end
            SETTLE: begin
                if (!w_lock)                     w_state_nxt = WAIT_LOCK;
                else if (r_cnt == SETTLE_LAST)   w_state_nxt = DP_RST;
            end
            DP_RST:    if (r_cnt == PULSE_LAST) w_state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (w_txd && w_rxd)              w_state_nxt = DONE;
                else if (!w_lock)                w_state_nxt = GT_RST;
                else if (r_cnt == TIMEOUT_LAST)  w_timeout   = 1'b1;
            end
            DONE: begin
                if (!w_lock || !w_txd || !w_rxd || retry_req) begin
                    w_state_nxt = GT_RST;
                    w_retry_nxt = 4'd0;
                end
            end
            FAIL: begin
                if (retry_req) begin
                    w_state_nxt = GT_RST;
                    w_retry_nxt = 4'd0;
                end
            end
            default:   w_state_nxt = IDLE;
        endcase
        if (w_timeout) begin
            w_retry_nxt = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
            w_state_nxt = (r_retry == RETRY_LAST) ? FAIL : GT_RST;
        end
    end

    // Outputs are decoded from the next state so they change in step with state_out.
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_retry  <= 4'd0;
            r_gt_rst <= 1'b1;
            r_dp_rst <= 1'b1;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_retry  <= w_retry_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_cnt != '1)       r_cnt <= r_cnt + 1'b1;
            r_gt_rst <= (w_state_nxt == IDLE) || (w_state_nxt == GT_RST) || (w_state_nxt == FAIL);
            r_dp_rst <= (w_state_nxt != WAIT_DONE) && (w_state_nxt != DONE);
            r_done   <= (w_state_nxt == DONE);
            r_fail   <= (w_state_nxt == FAIL);
        end
    end

    assign gt_reset_out    = r_gt_rst;
    assign tx_dp_reset_out = r_dp_rst;
    assign rx_dp_reset_out = r_dp_rst;
    assign seq_done        = r_done;
    assign seq_fail        = r_fail;
    assign retry_count     = r_retry;
    assign state_out       = r_state;

endmodule

// File: tb/tb_gtfraw_vnc_reset_sequencer.sv
// Directed bench for gtfraw_vnc_reset_sequencer: nominal bring-up, lock timeout to FAIL,
// lock glitch in SETTLE, reset-done timeout, lock loss in DONE and async reset mid-sequence.
module tb_gtfraw_vnc_reset_sequencer;

    logic       clk;
    logic       reset_async;
    logic       pll_lock_async;
    logic       tx_resetdone_async;
    logic       rx_resetdone_async;
    logic       retry_req;
    logic       gt_reset_out;
    logic       tx_dp_reset_out;
    logic       rx_dp_reset_out;
    logic       seq_done;
    logic       seq_fail;
    logic [3:0] retry_count;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    gtfraw_vnc_reset_sequencer #(
        .SYNC_STAGES       (3),
        .RESET_PULSE_CYCLES(4),
        .LOCK_SETTLE_CYCLES(8),
        .TIMEOUT_CYCLES    (32),
        .MAX_RETRIES       (3)
    ) dut (
        .clk               (clk),
        .reset_async       (reset_async),
        .pll_lock_async    (pll_lock_async),
        .tx_resetdone_async(tx_resetdone_async),
        .rx_resetdone_async(rx_resetdone_async),
        .retry_req         (retry_req),
        .gt_reset_out      (gt_reset_out),
        .tx_dp_reset_out   (tx_dp_reset_out),
        .rx_dp_reset_out   (rx_dp_reset_out),
        .seq_done          (seq_done),
        .seq_fail          (seq_fail),
        .retry_count       (retry_count),
        .state_out         (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gt"},    8'(gt_reset_out),    8'd1);
        check({tag, "_txdp"},  8'(tx_dp_reset_out), 8'd1);
        check({tag, "_rxdp"},  8'(rx_dp_reset_out), 8'd1);
        check({tag, "_done"},  8'(seq_done),        8'd0);
        check({tag, "_fail"},  8'(seq_fail),        8'd0);
        check({tag, "_retry"}, 8'(retry_count),     8'd0);
        check({tag, "_state"}, 8'(state_out),       8'd0);
    endtask

    // Holds reset for two edges with the given lock level, then releases just after an edge.
    task automatic do_reset(input logic lock_init);
        reset_async        = 1'b0;
        pll_lock_async     = lock_init;
        tx_resetdone_async = 1'b0;
        rx_resetdone_async = 1'b0;
        retry_req          = 1'b0;
        tick(2);
        check_reset_values("rst");
        reset_async = 1'b1;
    endtask

    task automatic pulse_retry();
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
    endtask

    initial begin
        reset_async        = 1'b0;
        pll_lock_async     = 1'b0;
        tx_resetdone_async = 1'b0;
        rx_resetdone_async = 1'b0;
        retry_req          = 1'b0;

        // Nominal bring-up with lock present from the start.
        do_reset(1'b1);
        tick(1);  check("nom_gtrst_state", 8'(state_out), 8'd1);
        tick(3);  check("nom_gt_held", 8'(gt_reset_out), 8'd1);
        tick(1);  check("nom_gt_fall", 8'(gt_reset_out), 8'd0);
                  check("nom_waitlock", 8'(state_out), 8'd2);
        tick(1);  check("nom_settle", 8'(state_out), 8'd3);
        tick(7);  check("nom_settle_end", 8'(state_out), 8'd3);
                  check("nom_dp_held", 8'(tx_dp_reset_out), 8'd1);
        tick(1);  check("nom_dprst", 8'(state_out), 8'd4);
        tick(3);  check("nom_dp_still", 8'(rx_dp_reset_out), 8'd1);
        tick(1);  check("nom_txdp_fall", 8'(tx_dp_reset_out), 8'd0);
                  check("nom_rxdp_fall", 8'(rx_dp_reset_out), 8'd0);
                  check("nom_waitdone", 8'(state_out), 8'd5);
        tick(10);
        tx_resetdone_async = 1'b1;
        rx_resetdone_async = 1'b1;
        tick(3);  check("nom_done_early", 8'(seq_done), 8'd0);
        tick(1);  check("nom_done", 8'(seq_done), 8'd1);
                  check("nom_done_state", 8'(state_out), 8'd6);

        // Lock lost while DONE, then a full re-run to DONE.
        pll_lock_async = 1'b0;
        tick(3);  check("loss_done_held", 8'(seq_done), 8'd1);
        tick(1);  check("loss_done_drop", 8'(seq_done), 8'd0);
                  check("loss_gt", 8'(gt_reset_out), 8'd1);
                  check("loss_state", 8'(state_out), 8'd1);
                  check("loss_retry", 8'(retry_count), 8'd0);
        pll_lock_async = 1'b1;
        tick(4);  check("rerun_waitlock", 8'(state_out), 8'd2);
        tick(1);  check("rerun_settle", 8'(state_out), 8'd3);
        tick(8);  check("rerun_dprst", 8'(state_out), 8'd4);
        tick(4);  check("rerun_waitdone", 8'(state_out), 8'd5);
        tick(1);  check("rerun_done", 8'(seq_done), 8'd1);
        pulse_retry();
        check("done_retry_state", 8'(state_out), 8'd1);
        check("done_retry_done", 8'(seq_done), 8'd0);

        // Lock never asserts: three timeouts then FAIL.
        do_reset(1'b0);
        tick(5);  check("nl_waitlock", 8'(state_out), 8'd2);
        tick(10);
        pulse_retry();
        check("nl_retry_ignored", 8'(state_out), 8'd2);
        tick(20); check("nl_to1_before", 8'(state_out), 8'd2);
        tick(1);  check("nl_to1_state", 8'(state_out), 8'd1);
                  check("nl_to1_retry", 8'(retry_count), 8'd1);
        tick(4);  check("nl_wl2", 8'(state_out), 8'd2);
        tick(31); check("nl_to2_before", 8'(state_out), 8'd2);
        tick(1);  check("nl_to2_retry", 8'(retry_count), 8'd2);
        tick(4);  check("nl_wl3", 8'(state_out), 8'd2);
        tick(32); check("nl_fail_state", 8'(state_out), 8'd7);
                  check("nl_fail_flag", 8'(seq_fail), 8'd1);
                  check("nl_fail_retry", 8'(retry_count), 8'd3);
                  check("nl_fail_gt", 8'(gt_reset_out), 8'd1);
                  check("nl_fail_dp", 8'(tx_dp_reset_out), 8'd1);
        tick(5);  check("nl_fail_stays", 8'(state_out), 8'd7);
        pulse_retry();
        check("nl_retry_state", 8'(state_out), 8'd1);
        check("nl_retry_count", 8'(retry_count), 8'd0);
        check("nl_retry_fail", 8'(seq_fail), 8'd0);

        // One-cycle lock glitch seen by the FSM in SETTLE cycle 5.
        do_reset(1'b1);
        tick(6);  check("gl_settle", 8'(state_out), 8'd3);
        tick(2);
        pll_lock_async = 1'b0;
        tick(1);
        pll_lock_async = 1'b1;
        tick(3);  check("gl_back_waitlock", 8'(state_out), 8'd2);
                  check("gl_retry", 8'(retry_count), 8'd0);
        tick(1);  check("gl_resettle", 8'(state_out), 8'd3);
        tick(7);  check("gl_settle_end", 8'(state_out), 8'd3);
        tick(1);  check("gl_dprst", 8'(state_out), 8'd4);
        tick(3);  check("gl_dp_held", 8'(tx_dp_reset_out), 8'd1);
        tick(1);  check("gl_dp_fall", 8'(tx_dp_reset_out), 8'd0);
                  check("gl_waitdone", 8'(state_out), 8'd5);

        // Only TX reset-done arrives: WAIT_DONE timeout.
        tx_resetdone_async = 1'b1;
        tick(31); check("txo_before", 8'(state_out), 8'd5);
        tick(1);  check("txo_state", 8'(state_out), 8'd1);
                  check("txo_retry", 8'(retry_count), 8'd1);
                  check("txo_gt", 8'(gt_reset_out), 8'd1);
                  check("txo_dp", 8'(rx_dp_reset_out), 8'd1);

        // Asynchronous reset during DP_RST, observed between clock edges.
        do_reset(1'b1);
        tick(15); check("ar_dprst", 8'(state_out), 8'd4);
        #2;
        reset_async = 1'b0;
        #1;
        check_reset_values("ar_mid");
        tick(1);  check("ar_hold", 8'(state_out), 8'd0);
        reset_async = 1'b1;
        tick(1);  check("ar_restart", 8'(state_out), 8'd1);
        tick(4);  check("ar_waitlock", 8'(state_out), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
